// File: rtl/cajero_pkg.sv
// Shared types and width helpers for the multi-account ATM controller.
package cajero_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN,
    ST_ESPERA,
    ST_DEPOSITO,
    ST_RETIRO,
    ST_BLOQUEADO
  } estado_t;

  localparam int N_DIGITOS_DEF   = 4;
  localparam int ANCHO_MONTO_DEF = 32;
  localparam int ANCHO_PIN_DEF   = 4 * N_DIGITOS_DEF;

  function automatic int ancho_cnt(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cajero_multicuenta_if.sv
// Front-end bus: card reader, keypad strobes and dispenser pulses.
interface cajero_multicuenta_if #(
  parameter int N_DIGITOS   = 4,
  parameter int ANCHO_MONTO = 32,
  parameter int N_CUENTAS   = 4
);
  logic                         TARJETA_RECIBIDA;
  logic [$clog2(N_CUENTAS)-1:0] CUENTA_ID;
  logic [4*N_DIGITOS-1:0]       PIN;
  logic [3:0]                   DIGITO;
  logic                         DIGITO_STB;
  logic                         TIPO_TRANS;
  logic                         TIPO_STB;
  logic [ANCHO_MONTO-1:0]       MONTO;
  logic                         MONTO_STB;
  logic                         DESBLOQUEO_STB;
  logic                         BALANCE_ACTUALIZADO;
  logic                         ENTREGAR_DINERO;
  logic                         FONDOS_INSUFICIENTES;
  logic                         PIN_INCORRECTO;
  logic                         LIMITE_EXCEDIDO;
  logic                         TIMEOUT;
  logic                         ADVERTENCIA;
  logic                         BLOQUEO;
  logic [ANCHO_MONTO-1:0]       BALANCE;

  modport master (
    output TARJETA_RECIBIDA, CUENTA_ID, PIN, DIGITO, DIGITO_STB,
    output TIPO_TRANS, TIPO_STB, MONTO, MONTO_STB, DESBLOQUEO_STB,
    input  BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
    input  PIN_INCORRECTO, LIMITE_EXCEDIDO, TIMEOUT,
    input  ADVERTENCIA, BLOQUEO, BALANCE
  );

  modport slave (
    input  TARJETA_RECIBIDA, CUENTA_ID, PIN, DIGITO, DIGITO_STB,
    input  TIPO_TRANS, TIPO_STB, MONTO, MONTO_STB, DESBLOQUEO_STB,
    output BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
    output PIN_INCORRECTO, LIMITE_EXCEDIDO, TIMEOUT,
    output ADVERTENCIA, BLOQUEO, BALANCE
  );
endinterface

// File: rtl/cajero_cuentas.sv
// Per-account balance, attempt counter and lock bit.
// One indexed read port and one whole-record write port.
module cajero_cuentas #(
  parameter int N_CUENTAS   = 4,
  parameter int ANCHO_MONTO = 32,
  parameter int ANCHO_INT   = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [$clog2(N_CUENTAS)-1:0] idx,
  input  logic                         we,
  input  logic [ANCHO_MONTO-1:0]       wr_saldo,
  input  logic [ANCHO_INT-1:0]         wr_int,
  input  logic                         wr_lock,
  output logic [ANCHO_MONTO-1:0]       rd_saldo,
  output logic [ANCHO_INT-1:0]         rd_int,
  output logic                         rd_lock
);

  logic [ANCHO_MONTO-1:0] saldo [N_CUENTAS];
  logic [ANCHO_INT-1:0]   inten [N_CUENTAS];
  logic [N_CUENTAS-1:0]   lock;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_CUENTAS; i++) begin
        saldo[i] <= '0;
        inten[i] <= '0;
      end
      lock <= '0;
    end else if (we) begin
      saldo[idx] <= wr_saldo;
      inten[idx] <= wr_int;
      lock[idx]  <= wr_lock;
    end
  end

  assign rd_saldo = saldo[idx];
  assign rd_int   = inten[idx];
  assign rd_lock  = lock[idx];

endmodule

// File: rtl/cajero_multicuenta.sv
// ATM session FSM, keypad PIN assembler and inactivity timer
// in front of the per-account store.
module cajero_multicuenta
  import cajero_pkg::*;
#(
  parameter int N_DIGITOS      = N_DIGITOS_DEF,
  parameter int MAX_INTENTOS   = 3,
  parameter int ANCHO_MONTO    = ANCHO_MONTO_DEF,
  parameter int N_CUENTAS      = 4,
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int LIMITE_RETIRO  = 5000
) (
  input logic Clk,
  input logic Reset,
  cajero_multicuenta_if.slave bus
);

  localparam int AW  = $clog2(N_CUENTAS);
  localparam int CW  = ancho_cnt(N_DIGITOS);
  localparam int IW  = ancho_cnt(MAX_INTENTOS);
  localparam int TW  = ancho_cnt(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] CNT_LLENO = CW'(N_DIGITOS);
  localparam logic [IW-1:0] INT_ULT   = IW'(MAX_INTENTOS - 1);
  localparam logic [TW-1:0] T_LIM     = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [ANCHO_MONTO-1:0] LIM = ANCHO_MONTO'(LIMITE_RETIRO);

  estado_t est, nxt;
  logic [AW-1:0]          cuenta, idx;
  logic [CW-1:0]          cnt;
  logic [4*N_DIGITOS-1:0] pin_buf;
  logic [TW-1:0]          tmr;

  logic                   we, wr_lock, rd_lock;
  logic [ANCHO_MONTO-1:0] wr_saldo, rd_saldo;
  logic [IW-1:0]          wr_int, rd_int;
  logic [ANCHO_MONTO:0]   suma;
  logic activo, any_stb, clr_dig;
  logic p_bal, p_ent, p_fon, p_pin, p_lim, p_to;

  assign idx     = (est == ST_IDLE) ? bus.CUENTA_ID : cuenta;
  assign suma    = {1'b0, rd_saldo} + {1'b0, bus.MONTO};
  assign activo  = (est == ST_PIN) || (est == ST_ESPERA) ||
                   (est == ST_DEPOSITO) || (est == ST_RETIRO);
  assign any_stb = bus.DIGITO_STB | bus.TIPO_STB |
                   bus.MONTO_STB | bus.DESBLOQUEO_STB;

  cajero_cuentas #(
    .N_CUENTAS   (N_CUENTAS),
    .ANCHO_MONTO (ANCHO_MONTO),
    .ANCHO_INT   (IW)
  ) u_cuentas (
    .Clk      (Clk),
    .Reset    (Reset),
    .idx      (idx),
    .we       (we),
    .wr_saldo (wr_saldo),
    .wr_int   (wr_int),
    .wr_lock  (wr_lock),
    .rd_saldo (rd_saldo),
    .rd_int   (rd_int),
    .rd_lock  (rd_lock)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      est     <= ST_IDLE;
      cuenta  <= '0;
      cnt     <= '0;
      pin_buf <= '0;
      tmr     <= '0;
    end else begin
      est <= nxt;
      if (est == ST_IDLE && bus.TARJETA_RECIBIDA)
        cuenta <= bus.CUENTA_ID;
      if (clr_dig) begin
        cnt     <= '0;
        pin_buf <= '0;
      end else if (est == ST_PIN && cnt != CNT_LLENO && bus.DIGITO_STB) begin
        for (int k = 0; k < N_DIGITOS; k++)
          if (cnt == CW'(k)) pin_buf[4*k +: 4] <= bus.DIGITO;
        cnt <= cnt + 1'b1;
      end
      // restart on any activity so a retried PIN gets a full window
      if (!activo || nxt != est || any_stb || we)
        tmr <= '0;
      else
        tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    nxt      = est;
    we       = 1'b0;
    wr_saldo = rd_saldo;
    wr_int   = rd_int;
    wr_lock  = rd_lock;
    clr_dig  = 1'b0;
    p_bal    = 1'b0;
    p_ent    = 1'b0;
    p_fon    = 1'b0;
    p_pin    = 1'b0;
    p_lim    = 1'b0;
    p_to     = 1'b0;
    if (activo && !bus.TARJETA_RECIBIDA) begin
      nxt     = ST_IDLE;
      clr_dig = 1'b1;
    end else begin
      unique case (est)
        ST_IDLE: begin
          clr_dig = 1'b1;
          if (bus.DESBLOQUEO_STB) begin
            we      = 1'b1;
            wr_int  = '0;
            wr_lock = 1'b0;
          end
          if (bus.TARJETA_RECIBIDA)
            nxt = rd_lock ? ST_BLOQUEADO : ST_PIN;
        end
        ST_PIN: begin
          if (cnt == CNT_LLENO) begin
            we = 1'b1;
            if (pin_buf == bus.PIN) begin
              wr_int = '0;
              nxt    = ST_ESPERA;
            end else begin
              p_pin   = 1'b1;
              clr_dig = 1'b1;
              if (rd_int == INT_ULT) begin
                wr_lock = 1'b1;
                wr_int  = '0;
                nxt     = ST_BLOQUEADO;
              end else begin
                wr_int = rd_int + 1'b1;
              end
            end
          end
        end
        ST_ESPERA: begin
          if (bus.TIPO_STB)
            nxt = bus.TIPO_TRANS ? ST_RETIRO : ST_DEPOSITO;
        end
        ST_DEPOSITO: begin
          if (bus.MONTO_STB) begin
            nxt = ST_IDLE;
            if (suma[ANCHO_MONTO]) begin
              p_lim = 1'b1;
            end else begin
              we       = 1'b1;
              wr_saldo = suma[ANCHO_MONTO-1:0];
              p_bal    = 1'b1;
            end
          end
        end
        ST_RETIRO: begin
          if (bus.MONTO_STB) begin
            nxt = ST_IDLE;
            if (bus.MONTO > LIM) begin
              p_lim = 1'b1;
            end else if (bus.MONTO > rd_saldo) begin
              p_fon = 1'b1;
            end else begin
              we       = 1'b1;
              wr_saldo = rd_saldo - bus.MONTO;
              p_bal    = 1'b1;
              p_ent    = 1'b1;
            end
          end
        end
        ST_BLOQUEADO: begin
          if (!bus.TARJETA_RECIBIDA) nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
      if (activo && !any_stb && !we && nxt == est && tmr == T_LIM) begin
        p_to    = 1'b1;
        nxt     = ST_IDLE;
        clr_dig = 1'b1;
      end
    end
  end

  assign bus.BALANCE_ACTUALIZADO  = p_bal;
  assign bus.ENTREGAR_DINERO      = p_ent;
  assign bus.FONDOS_INSUFICIENTES = p_fon;
  assign bus.PIN_INCORRECTO       = p_pin;
  assign bus.LIMITE_EXCEDIDO      = p_lim;
  assign bus.TIMEOUT              = p_to;
  assign bus.ADVERTENCIA = (est == ST_PIN) && (rd_int == INT_ULT);
  assign bus.BLOQUEO     = (est == ST_BLOQUEADO);
  assign bus.BALANCE     = (est == ST_IDLE) ? '0 : rd_saldo;

endmodule

// File: tb/tb_cajero_multicuenta.sv
// Directed bench for cajero_multicuenta: sessions, locks, limits,
// timeout and asynchronous reset.
module tb_cajero_multicuenta;

  localparam int ND = 4;
  localparam int AM = 32;
  localparam int NC = 4;
  localparam int TO = 20;

  localparam logic [5:0] P_BAL = 6'b100000;
  localparam logic [5:0] P_ENT = 6'b010000;
  localparam logic [5:0] P_FON = 6'b001000;
  localparam logic [5:0] P_PIN = 6'b000100;
  localparam logic [5:0] P_LIM = 6'b000010;
  localparam logic [5:0] P_TO  = 6'b000001;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  cajero_multicuenta_if #(
    .N_DIGITOS(ND), .ANCHO_MONTO(AM), .N_CUENTAS(NC)
  ) b ();

  cajero_multicuenta #(
    .N_DIGITOS      (ND),
    .MAX_INTENTOS   (3),
    .ANCHO_MONTO    (AM),
    .N_CUENTAS      (NC),
    .TIMEOUT_CICLOS (TO),
    .LIMITE_RETIRO  (5000)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pulsos();
    return {b.BALANCE_ACTUALIZADO, b.ENTREGAR_DINERO,
            b.FONDOS_INSUFICIENTES, b.PIN_INCORRECTO,
            b.LIMITE_EXCEDIDO, b.TIMEOUT};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic teclear(input logic [3:0] d);
    b.DIGITO = d;
    b.DIGITO_STB = 1'b1;
    tick();
    b.DIGITO_STB = 1'b0;
  endtask

  task automatic entrar_pin(input logic [15:0] v, input logic [5:0] exp,
                            input string tag);
    logic [15:0] t;
    t = v;
    for (int k = 0; k < 4; k++) teclear(t[4*k +: 4]);
    @(negedge Clk);
    chk(tag, pulsos(), exp);
    tick();
  endtask

  task automatic insertar(input logic [1:0] id, input logic [15:0] pin);
    b.CUENTA_ID = id;
    b.PIN = pin;
    b.TARJETA_RECIBIDA = 1'b1;
    tick();
  endtask

  task automatic retirar_tarjeta();
    b.TARJETA_RECIBIDA = 1'b0;
    tick();
  endtask

  task automatic abrir(input logic [1:0] id, input logic [15:0] pin);
    insertar(id, pin);
    entrar_pin(pin, 6'b0, "pin_ok");
  endtask

  task automatic tipo(input logic t);
    b.TIPO_TRANS = t;
    b.TIPO_STB = 1'b1;
    tick();
    b.TIPO_STB = 1'b0;
  endtask

  task automatic monto(input logic [31:0] m, input logic [5:0] exp,
                       input string tag);
    b.MONTO = m;
    b.MONTO_STB = 1'b1;
    @(negedge Clk);
    chk(tag, pulsos(), exp);
    tick();
    b.MONTO_STB = 1'b0;
    retirar_tarjeta();
  endtask

  initial begin
    int k_to;
    b.TARJETA_RECIBIDA = 0; b.CUENTA_ID = 0; b.PIN = 0;
    b.DIGITO = 0; b.DIGITO_STB = 0; b.TIPO_TRANS = 0; b.TIPO_STB = 0;
    b.MONTO = 0; b.MONTO_STB = 0; b.DESBLOQUEO_STB = 0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_pulsos", pulsos(), 6'b0);
    chk("rst_balance", b.BALANCE, 0);
    chk("rst_bloqueo", b.BLOQUEO, 0);
    chk("rst_advert", b.ADVERTENCIA, 0);
    tick();
    Reset = 1'b1;
    tick();

    // deposit then full withdrawal on account 1
    abrir(1, 16'h4321);
    chk("c1_bal_ini", b.BALANCE, 0);
    tipo(0);
    monto(700, P_BAL, "dep700");
    chk("idle_balance0", b.BALANCE, 0);
    abrir(1, 16'h4321);
    chk("c1_bal_700", b.BALANCE, 700);
    tipo(1);
    monto(700, P_BAL | P_ENT, "ret700");
    abrir(1, 16'h4321);
    chk("c1_bal_0", b.BALANCE, 0);
    retirar_tarjeta();

    // three wrong PINs lock account 2
    insertar(2, 16'h1111);
    entrar_pin(16'h9999, P_PIN, "mal1");
    chk("adv_tras1", b.ADVERTENCIA, 0);
    entrar_pin(16'h9999, P_PIN, "mal2");
    chk("adv_tras2", b.ADVERTENCIA, 1);
    entrar_pin(16'h9999, P_PIN, "mal3");
    chk("bloq_c2", b.BLOQUEO, 1);
    chk("adv_bloq", b.ADVERTENCIA, 0);
    retirar_tarjeta();
    chk("bloq_idle", b.BLOQUEO, 0);
    insertar(2, 16'h1111);
    chk("bloq_reins", b.BLOQUEO, 1);
    retirar_tarjeta();
    insertar(0, 16'h5678);
    chk("c0_libre", b.BLOQUEO, 0);
    entrar_pin(16'h5678, 6'b0, "c0_pin");
    retirar_tarjeta();

    b.CUENTA_ID = 2;
    b.DESBLOQUEO_STB = 1'b1;
    tick();
    b.DESBLOQUEO_STB = 1'b0;
    insertar(2, 16'h1111);
    chk("desbloq", b.BLOQUEO, 0);
    entrar_pin(16'h1111, 6'b0, "c2_pin");
    tipo(0);
    monto(100, P_BAL, "dep100");

    // limit cases with balance 100
    abrir(2, 16'h1111);
    tipo(1);
    monto(101, P_FON, "ret101");
    abrir(2, 16'h1111);
    tipo(1);
    monto(6000, P_LIM, "ret6000");
    abrir(2, 16'h1111);
    tipo(0);
    monto(32'hFFFF_FFCE, P_LIM, "dep_ovf");
    abrir(2, 16'h1111);
    chk("c2_bal_100", b.BALANCE, 100);
    tipo(1);
    monto(0, P_BAL | P_ENT, "ret0");

    // inactivity timeout after two digits
    insertar(3, 16'h9876);
    teclear(4'h6);
    teclear(4'h7);
    k_to = 0;
    for (int k = 1; k <= 2 * TO; k++) begin
      @(negedge Clk);
      if (b.TIMEOUT) begin
        k_to = k;
        chk("to_pulsos", pulsos(), P_TO);
        break;
      end
      tick();
    end
    chk("to_ciclos", k_to, TO);
    tick();
    chk("to_idle_bal", b.BALANCE, 0);
    retirar_tarjeta();

    // card removal keeps attempts, drops partial PIN
    insertar(2, 16'h1111);
    entrar_pin(16'h9999, P_PIN, "rm_mal1");
    teclear(4'h1);
    teclear(4'h1);
    teclear(4'h1);
    retirar_tarjeta();
    insertar(2, 16'h1111);
    chk("rm_adv0", b.ADVERTENCIA, 0);
    entrar_pin(16'h9999, P_PIN, "rm_mal2");
    chk("rm_adv1", b.ADVERTENCIA, 1);
    entrar_pin(16'h1111, 6'b0, "rm_pin_ok");
    chk("rm_bal", b.BALANCE, 100);
    retirar_tarjeta();

    // lock account 3, then reset mid-withdrawal
    insertar(3, 16'h9876);
    entrar_pin(16'h0000, P_PIN, "c3_mal1");
    entrar_pin(16'h0000, P_PIN, "c3_mal2");
    entrar_pin(16'h0000, P_PIN, "c3_mal3");
    chk("c3_bloq", b.BLOQUEO, 1);
    retirar_tarjeta();
    abrir(2, 16'h1111);
    tipo(1);
    b.MONTO = 50;
    b.MONTO_STB = 1'b1;
    #1;
    chk("pre_rst", pulsos(), P_BAL | P_ENT);
    Reset = 1'b0;
    #1;
    chk("rst_async_p", pulsos(), 6'b0);
    chk("rst_async_b", b.BALANCE, 0);
    b.MONTO_STB = 1'b0;
    b.TARJETA_RECIBIDA = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    abrir(2, 16'h1111);
    chk("rst_c2_bal", b.BALANCE, 0);
    retirar_tarjeta();
    abrir(1, 16'h4321);
    chk("rst_c1_bal", b.BALANCE, 0);
    retirar_tarjeta();
    insertar(3, 16'h9876);
    chk("rst_c3_lock", b.BLOQUEO, 0);
    retirar_tarjeta();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cajero_multicuenta.md
# cajero_multicuenta

Parametrised ATM transaction controller serving `N_CUENTAS` accounts behind one keypad/card-reader front end. It is the next-generation `cajero` controller and adds:
- configurable PIN length, attempt limit and amount width;
- per-account balance, attempt counter and persistent lock;
- an inactivity timeout;
- a per-transaction withdrawal cap and deposit-overflow rejection.

It sits between the card reader/keypad strobes and the cash dispenser, using Mealy pulse outputs.

## Interface
- `N_DIGITOS`, 4, PIN length in decimal digits (1–8)
- `MAX_INTENTOS`, 3, wrong PINs before account lock (2–7)
- `ANCHO_MONTO`, 32, width of `MONTO` and balances
- `N_CUENTAS`, 4, number of accounts (power of 2, ≥2)
- `TIMEOUT_CICLOS`, 1000, idle cycles before session abort
- `LIMITE_RETIRO`, 5000, maximum single withdrawal
---
- `Clk` input 1: single clock, rising edge
- `Reset` input 1: asynchronous, active-low; clears all state including balances and locks
- `TARJETA_RECIBIDA` input 1: level, card present
- `CUENTA_ID` input log2(N_CUENTAS): account of inserted card, sampled on insertion
- `PIN` input 4·N_DIGITOS: card's expected PIN, BCD nibbles, digit k at [4k+3:4k]
- `DIGITO` input 4, `DIGITO_STB` input 1: keypad digit + 1-cycle strobe
- `TIPO_TRANS` input 1 (0 deposit, 1 withdrawal), `TIPO_STB` input 1
- `MONTO` input ANCHO_MONTO, `MONTO_STB` input 1
- `DESBLOQUEO_STB` input 1: bank-side clear of lock + attempts for `CUENTA_ID`; honoured only in IDLE
- `BALANCE_ACTUALIZADO`, `ENTREGAR_DINERO`, `FONDOS_INSUFICIENTES`, `PIN_INCORRECTO`, `LIMITE_EXCEDIDO`, `TIMEOUT` output 1: 1-cycle pulses
- `ADVERTENCIA` output 1: level, in PIN state with attempts == MAX_INTENTOS−1
- `BLOQUEO` output 1: level, high in BLOQUEADO
- `BALANCE` output ANCHO_MONTO: balance of the active account; 0 in IDLE

## Operation
States: IDLE, PIN, ESPERA_TIPO, DEPOSITO, RETIRO, BLOQUEADO. All outputs are 0 at reset and in IDLE.

**IDLE**
- `TARJETA_RECIBIDA`=1: latch `CUENTA_ID`.
- Go to BLOQUEADO if that account is locked, else to PIN.
- Clear digit count and assembled PIN.

**PIN**
- Each `DIGITO_STB` stores `DIGITO` at nibble index = count, then count++.
- Strobes after count == N_DIGITOS are ignored.
- The cycle count == N_DIGITOS, compare with `PIN`:
  - Match: clear account attempts, go to ESPERA_TIPO.
  - Mismatch: `PIN_INCORRECTO` pulse, attempts++, clear digits.
  - Mismatch where attempts+1 == MAX_INTENTOS: also set the lock bit, clear attempts, go to BLOQUEADO.

**ESPERA_TIPO**
- `TIPO_STB` selects DEPOSITO (0) or RETIRO (1).

**DEPOSITO**, on `MONTO_STB`:
- If balance+MONTO overflows ANCHO_MONTO bits: `LIMITE_EXCEDIDO`, balance unchanged.
- Otherwise: balance += MONTO, `BALANCE_ACTUALIZADO`.
- Either way, go to IDLE.

**RETIRO**, on `MONTO_STB`, priority order:
1. MONTO > LIMITE_RETIRO → `LIMITE_EXCEDIDO`.
2. MONTO > balance → `FONDOS_INSUFICIENTES`.
3. Otherwise balance −= MONTO, `BALANCE_ACTUALIZADO` + `ENTREGAR_DINERO`.

Always go to IDLE afterwards. MONTO == balance is allowed and leaves balance 0. MONTO == 0 is a valid transaction.

**BLOQUEADO**
- Hold until `TARJETA_RECIBIDA`=0, then go to IDLE.
- The lock persists per account across sessions; only `DESBLOQUEO_STB` or `Reset` clears it.

**Card removal and timeout**
- Card removal in PIN/ESPERA_TIPO/DEPOSITO/RETIRO → IDLE, no pulse, partial PIN discarded, attempts kept.
- Timeout counter: reset on state change or any strobe, counts in PIN/ESPERA_TIPO/DEPOSITO/RETIRO.
- On reaching TIMEOUT_CICLOS−1: `TIMEOUT` pulse, go to IDLE.

## Timing
- All pulse outputs are combinational from the current state + strobes, valid in the strobe cycle. State and balance update on the next `Clk` edge.
- PIN check takes one cycle after the last digit's strobe; strobes in the compare cycle are ignored.
- Transaction latency is 1 cycle from `MONTO_STB` to updated `BALANCE`.
- Simultaneous events in one cycle:
  - Card removal beats any strobe.
  - A strobe beats timeout.
  - `TIPO_STB` during PIN is ignored.
  - `MONTO_STB` outside DEPOSITO/RETIRO is ignored.
- `Reset` assertion mid-operation forces IDLE immediately (asynchronously).

## Structure
- Package `cajero_pkg`: state enum, `N_DIGITOS`/`ANCHO_MONTO` derived width localparams.
- Sub-module `cajero_cuentas`:
  - Per-account balance registers, attempt counters and lock bits.
  - Read port indexed by the latched account; one write port per cycle.
- The top level holds the FSM, digit assembler and timeout counter.

## Test plan
- Account 1, PIN 0x4321, digits 1,2,3,4, deposit 700 → `BALANCE_ACTUALIZADO`, `BALANCE`=700; withdrawal 700 → `ENTREGAR_DINERO`, `BALANCE`=0.
- Three wrong PINs on account 2 → `PIN_INCORRECTO` ×3, `ADVERTENCIA` after 2nd, then BLOQUEADO.
  - Reinserting account 2 → BLOQUEADO directly; account 0 is unaffected.
  - `DESBLOQUEO_STB` in IDLE clears the lock.
- Balance 100:
  - Withdraw 101 → `FONDOS_INSUFICIENTES`.
  - Withdraw 6000 → `LIMITE_EXCEDIDO` only.
  - Deposit 2^32−50 → `LIMITE_EXCEDIDO`, balance 100.
- Two digits entered, then no activity for TIMEOUT_CICLOS → `TIMEOUT` pulse, IDLE.
  - Card removed after 3 digits → IDLE, attempts unchanged.
- `Reset` low mid-RETIRO → all outputs 0, all balances 0, all locks cleared.
